// File: rtl/puf_pkg.sv
// Shared widths, record layout and sequencer state encoding for the PUF challenge sequencer.
package puf_pkg;

  localparam int unsigned PUF_WIDTH  = 8;
  localparam int unsigned CHAL_WIDTH = 8;

  // Record layout: {timeout_flag, challenge, response}
  localparam int unsigned RESP_LSB   = 0;
  localparam int unsigned CHAL_LSB   = RESP_LSB + PUF_WIDTH;
  localparam int unsigned TFLAG_BIT  = CHAL_LSB + CHAL_WIDTH;
  localparam int unsigned REC_WIDTH  = TFLAG_BIT + 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StMeasure = 3'd2,
    StCapture = 3'd3,
    StNext    = 3'd4
  } seq_state_e;

  function automatic logic [REC_WIDTH-1:0] pack_record(input logic                  tflag,
                                                       input logic [CHAL_WIDTH-1:0] chal,
                                                       input logic [PUF_WIDTH-1:0]  resp);
    logic [REC_WIDTH-1:0] rec;
    rec                           = '0;
    rec[TFLAG_BIT]                = tflag;
    rec[CHAL_LSB +: CHAL_WIDTH]   = chal;
    rec[RESP_LSB +: PUF_WIDTH]    = resp;
    return rec;
  endfunction

endpackage

// File: rtl/puf_resp_fifo.sv
// First-word-fall-through FIFO holding measurement records; a pop frees space for a
// same-cycle push even when full.
module puf_resp_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  // One extra pointer bit distinguishes full from empty.
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[Aw-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sweeps a challenge range over the PUF array, times each measurement and queues
// {timeout, challenge, response} records for the host link.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter logic [31:0] ENABLE_MASK    = 32'hFFFF_FFFF,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                  clock,
  input  logic                  computer_reset,
  input  logic                  start,
  input  logic [CHAL_WIDTH-1:0] first_challenge,
  input  logic [8:0]            num_challenges,
  output logic                  busy,
  output logic                  sweep_done,
  output logic [CHAL_WIDTH-1:0] puf_challenge,
  output logic [31:0]           puf_enable,
  input  logic [PUF_WIDTH-1:0]  puf_out,
  input  logic                  puf_all_done,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [REC_WIDTH-1:0]  resp_data
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  seq_state_e            state_q;
  logic [CHAL_WIDTH-1:0] cur_q;
  logic [8:0]            rem_q;
  logic [CntW-1:0]       cnt_q;
  logic                  tflag_q;
  logic                  busy_q;
  logic                  done_q;
  logic [31:0]           enable_q;

  logic                  fifo_full, fifo_empty;
  logic                  fifo_pop, fifo_push, capture_go;
  logic [REC_WIDTH-1:0]  fifo_wdata;

  assign fifo_pop   = resp_valid && resp_ready;
  assign fifo_push  = (state_q == StCapture);
  // Must agree with the FIFO's own accept rule so the FSM never drops a record.
  assign capture_go = fifo_push && (!fifo_full || fifo_pop);
  assign fifo_wdata = pack_record(tflag_q, cur_q, puf_out);

  always_ff @(posedge clock or posedge computer_reset) begin
    if (computer_reset) begin
      state_q  <= StIdle;
      cur_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      tflag_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enable_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_q   <= first_challenge;
            rem_q   <= (num_challenges == '0) ? 9'd256 : num_challenges;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          // Hold here while all_done is stuck high; there is no timeout in settle.
          if (cnt_q == SettleLast) begin
            if (!puf_all_done) begin
              cnt_q    <= '0;
              enable_q <= ENABLE_MASK;
              state_q  <= StMeasure;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StMeasure: begin
          if (puf_all_done) begin
            tflag_q <= 1'b0;
            state_q <= StCapture;
          end else if (cnt_q == TimeoutLast) begin
            tflag_q <= 1'b1;
            state_q <= StCapture;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCapture: begin
          if (capture_go) begin
            enable_q <= '0;
            state_q  <= StNext;
          end
        end
        StNext: begin
          if (rem_q == 9'd1) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cur_q   <= cur_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
            cnt_q   <= '0;
            state_q <= StSettle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  puf_resp_fifo #(
    .Width (REC_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clock),
    .rst_i   (computer_reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (resp_data)
  );

  assign resp_valid    = !fifo_empty;
  assign busy          = busy_q;
  assign sweep_done    = done_q;
  assign puf_challenge = cur_q;
  assign puf_enable    = enable_q;

endmodule
